// File: rtl/arrow_launcher_pkg.sv
// Shared types and helpers for the arrow launcher: FSM state encoding,
// shooter ID width and the saturating health subtract.
package arrow_pkg;

  typedef enum logic [2:0] {IDLE, LAUNCH, FLIGHT, COOLDOWN, DEAD} launch_state_t;

  localparam int SHOOTER_ID_W = 8;

  function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : 4'd0;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/arrow_launcher_if.sv
// Shot-protocol bundle between game logic, the launcher and the arrow animator.
// master = launcher side, slave = game logic / animator side.
interface arrow_launcher_if #(parameter int N_SHOOTERS = 4);
  import arrow_pkg::*;

  logic [N_SHOOTERS-1:0]   fire_req;
  logic                    hit;
  logic [SHOOTER_ID_W-1:0] who_shoot;
  logic [N_SHOOTERS-1:0]   fire_grant;
  logic                    busy;
  logic [3:0]              health;
  logic                    alive;
  logic [7:0]              hit_count;

  modport master (
    input  fire_req, hit,
    output who_shoot, fire_grant, busy, health, alive, hit_count
  );

  modport slave (
    output fire_req, hit,
    input  who_shoot, fire_grant, busy, health, alive, hit_count
  );

endinterface

// File: rtl/arrow_launcher_rr_arbiter.sv
// Combinational round-robin arbiter: the search for a set request starts at ptr
// and wraps; returns a one-hot grant, the granted index and a valid flag.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to ptr so the closest request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant       = '0;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arrow_launcher.sv
// Shot initiator: arbitrates fire requests, pulses who_shoot/fire_grant, waits out the
// flight and cooldown windows and tracks health. Optional regen under HEALTH_REGEN_EN.
module arrow_launcher
  import arrow_pkg::*;
#(
  parameter int N_SHOOTERS   = 4,
  parameter int RESULT_WIN   = 27000000,
  parameter int COOLDOWN_CYC = 1000000,
  parameter int MAX_HEALTH   = 10,
  parameter int DAMAGE       = 2,
  parameter int REGEN_CYC    = 50000000
) (
  input  logic               Clk,
  input  logic               Reset,
  arrow_launcher_if.master   bus
);

  localparam int IDX_W   = (N_SHOOTERS > 1) ? $clog2(N_SHOOTERS) : 1;
  localparam int CNT_MAX = max3(RESULT_WIN, COOLDOWN_CYC, REGEN_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  launch_state_t           state;
  logic [SHOOTER_ID_W-1:0] who_q;
  logic [N_SHOOTERS-1:0]   grant_q;
  logic                    busy_q;
  logic [3:0]              health_q;
  logic [7:0]              hit_count_q;
  logic [IDX_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]        flight_cnt;
  logic [CNT_W-1:0]        cd_cnt;
  logic                    hit_q;
  logic                    hit_taken;
`ifdef HEALTH_REGEN_EN
  logic [CNT_W-1:0]        regen_cnt;
`endif

  logic [N_SHOOTERS-1:0]   arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic                    alive;
  logic                    hit_accept;
  logic [3:0]              health_hit;

  rr_arbiter #(.N(N_SHOOTERS)) u_arb (
    .req   (bus.fire_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign alive      = (health_q != 4'd0);
  assign hit_accept = (state == FLIGHT) && bus.hit && !hit_q && !hit_taken;
  assign health_hit = sat_sub4(health_q, 4'(DAMAGE));

  always_ff @(posedge Clk) begin
    hit_q <= bus.hit;
    if (Reset) begin
      state       <= IDLE;
      who_q       <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      health_q    <= 4'(MAX_HEALTH);
      hit_count_q <= '0;
      rr_ptr      <= '0;
      flight_cnt  <= '0;
      cd_cnt      <= '0;
      hit_taken   <= 1'b0;
`ifdef HEALTH_REGEN_EN
      regen_cnt   <= '0;
`endif
    end else begin
      who_q   <= '0;
      grant_q <= '0;
      case (state)
        IDLE: begin
          if (alive && arb_valid) begin
            state   <= LAUNCH;
            who_q   <= SHOOTER_ID_W'(arb_idx) + SHOOTER_ID_W'(1);
            grant_q <= arb_grant;
            busy_q  <= 1'b1;
            rr_ptr  <= (arb_idx == IDX_W'(N_SHOOTERS - 1)) ? '0 : arb_idx + IDX_W'(1);
          end
        end
        LAUNCH: begin
          state      <= FLIGHT;
          flight_cnt <= '0;
          hit_taken  <= 1'b0;
        end
        FLIGHT: begin
          if (hit_accept) begin
            health_q    <= health_hit;
            hit_taken   <= 1'b1;
            if (hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
          end
          // A fatal hit wins over the end-of-window transition.
          if (hit_accept && health_hit == 4'd0) begin
            state  <= DEAD;
            busy_q <= 1'b0;
          end else if (flight_cnt == CNT_W'(RESULT_WIN - 1)) begin
            state  <= COOLDOWN;
            cd_cnt <= '0;
          end else begin
            flight_cnt <= flight_cnt + CNT_W'(1);
          end
        end
        COOLDOWN: begin
          if (cd_cnt == CNT_W'(COOLDOWN_CYC - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cd_cnt <= cd_cnt + CNT_W'(1);
          end
        end
        DEAD: begin
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
`ifdef HEALTH_REGEN_EN
      // Hits only land in FLIGHT, so regen never races a damage update.
      if ((state == IDLE || state == COOLDOWN) && alive && health_q < 4'(MAX_HEALTH)) begin
        if (regen_cnt == CNT_W'(REGEN_CYC - 1)) begin
          health_q  <= health_q + 4'd1;
          regen_cnt <= '0;
        end else begin
          regen_cnt <= regen_cnt + CNT_W'(1);
        end
      end else begin
        regen_cnt <= '0;
      end
`endif
    end
  end

  assign bus.who_shoot  = who_q;
  assign bus.fire_grant = grant_q;
  assign bus.busy       = busy_q;
  assign bus.health     = health_q;
  assign bus.alive      = alive;
  assign bus.hit_count  = hit_count_q;

endmodule

// File: tb/tb_arrow_launcher.sv
// Bench for arrow_launcher: shot-timeline model checked every cycle plus directed
// literal expectations. Regen scenario is built only with HEALTH_REGEN_EN.
module tb_arrow_launcher;

  localparam int NS   = 4;
  localparam int RW   = 20;
  localparam int CD   = 5;
  localparam int MAXH = 10;
  localparam int DMG  = 2;
  localparam int RG   = 8;

  logic Clk;
  logic Reset;

  arrow_launcher_if #(.N_SHOOTERS(NS)) bus ();

  arrow_launcher #(
    .N_SHOOTERS  (NS),
    .RESULT_WIN  (RW),
    .COOLDOWN_CYC(CD),
    .MAX_HEALTH  (MAXH),
    .DAMAGE      (DMG),
    .REGEN_CYC   (RG)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a shot is a timeline of 1+RW+CD cycles counted from launch (m_since),
  // -1 when resting; FLIGHT is m_since in 1..RW.
  int m_since  = -1;
  bit m_dead   = 1'b0;
  int m_health = MAXH;
  int m_hits   = 0;
  int m_ptr    = 0;
  int m_regen  = 0;
  bit m_taken  = 1'b0;
  bit m_hitp   = 1'b0;
  int m_who    = 0;
  int m_grant  = 0;
  bit m_valid  = 1'b0;

  always @(posedge Clk) begin
    bit rise;
    int s0;
    int h0;
    bit d0;
    rise   = bus.hit && !m_hitp;
    m_hitp = bus.hit;
    s0 = m_since;
    h0 = m_health;
    d0 = m_dead;
    if (Reset) begin
      m_since = -1; m_dead = 0; m_health = MAXH; m_hits = 0; m_ptr = 0;
      m_regen = 0; m_taken = 0; m_who = 0; m_grant = 0; m_valid = 1;
    end else begin
      m_who = 0;
      m_grant = 0;
      if (!m_dead) begin
        if (m_since < 0) begin
          if (bus.fire_req != '0) begin
            for (int k = 0; k < NS; k++) begin
              int j;
              j = (m_ptr + k) % NS;
              if (bus.fire_req[j] && m_since < 0) begin
                m_who = j + 1;
                m_grant = 1 << j;
                m_ptr = (j + 1) % NS;
                m_since = 0;
                m_taken = 0;
              end
            end
          end
        end else begin
          if (m_since >= 1 && m_since <= RW && rise && !m_taken) begin
            m_taken = 1;
            m_health = (m_health > DMG) ? m_health - DMG : 0;
            if (m_hits < 255) m_hits++;
          end
          if (m_health == 0) begin
            m_dead = 1;
            m_since = -1;
          end else begin
            m_since++;
            if (m_since == 1 + RW + CD) m_since = -1;
          end
        end
      end
`ifdef HEALTH_REGEN_EN
      if (!d0 && (s0 < 0 || s0 > RW) && h0 < MAXH) begin
        m_regen++;
        if (m_regen == RG) begin
          m_health = m_health + 1;
          m_regen = 0;
        end
      end else begin
        m_regen = 0;
      end
`endif
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("who_shoot",  int'(bus.who_shoot),  m_who);
      chk("fire_grant", int'(bus.fire_grant), m_grant);
      chk("busy",       int'(bus.busy),       (m_since >= 0) ? 1 : 0);
      chk("health",     int'(bus.health),     m_health);
      chk("alive",      int'(bus.alive),      (m_health != 0) ? 1 : 0);
      chk("hit_count",  int'(bus.hit_count),  m_hits);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
  endtask

  task automatic wait_who();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (bus.who_shoot != '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_who_in_time", int'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("wait_idle_in_time", int'(ok), 1);
  endtask

  task automatic shoot(input logic [NS-1:0] req);
    bus.fire_req = req;
    wait_who();
    bus.fire_req = '0;
  endtask

  int ids[5];
  int times[5];
  int got;
  int n;

  initial begin
    Reset = 1'b1;
    bus.fire_req = '0;
    bus.hit = 1'b0;
    cyc(3);
    Reset = 1'b0;
    chk("rst_health", int'(bus.health), 10);
    chk("rst_alive", int'(bus.alive), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_who", int'(bus.who_shoot), 0);
    chk("rst_hits", int'(bus.hit_count), 0);

    // Single request from shooter 2, one-cycle latency.
    bus.fire_req = 4'b0100;
    cyc(1);
    chk("first_who", int'(bus.who_shoot), 3);
    chk("first_grant", int'(bus.fire_grant), 4);
    bus.fire_req = '0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      n++;
      cyc(1);
    end
    chk("busy_len", n, 26);
    chk("who_after_launch", int'(bus.who_shoot), 0);

    // All shooters requesting: round-robin from pointer 0.
    do_reset();
    bus.fire_req = 4'b1111;
    got = 0;
    for (int t = 0; t < 300 && got < 5; t++) begin
      cyc(1);
      if (bus.who_shoot != '0) begin
        ids[got] = int'(bus.who_shoot);
        times[got] = t;
        got++;
      end
    end
    bus.fire_req = '0;
    chk("rr_shots_seen", got, 5);
    chk("rr_id0", ids[0], 1);
    chk("rr_id1", ids[1], 2);
    chk("rr_id2", ids[2], 3);
    chk("rr_id3", ids[3], 4);
    chk("rr_id4", ids[4], 1);
    for (int i = 1; i < 5; i++) chk("rr_period", times[i] - times[i-1], 27);
    wait_idle();

    // Hit rises 5 cycles into FLIGHT and stays high 10 cycles: one decrement.
    do_reset();
    shoot(4'b0001);
    cyc(5);
    bus.hit = 1'b1;
    cyc(10);
    bus.hit = 1'b0;
    chk("held_hit_health", int'(bus.health), 8);
    chk("held_hit_count", int'(bus.hit_count), 1);
    wait_idle();
    chk("held_hit_health_end", int'(bus.health), 8);

    // Hit already high before launch, never re-rising: no damage.
    do_reset();
    bus.hit = 1'b1;
    shoot(4'b0010);
    wait_idle();
    bus.hit = 1'b0;
    chk("pre_high_health", int'(bus.health), 10);
    chk("pre_high_count", int'(bus.hit_count), 0);

    // Hit pulse during COOLDOWN: ignored.
    shoot(4'b0010);
    cyc(22);
    chk("in_cooldown_busy", int'(bus.busy), 1);
    bus.hit = 1'b1;
    cyc(1);
    bus.hit = 1'b0;
    wait_idle();
    chk("cooldown_hit_health", int'(bus.health), 10);

    // Hit on the last FLIGHT cycle is accepted and COOLDOWN still follows.
    do_reset();
    shoot(4'b1000);
    cyc(20);
    bus.hit = 1'b1;
    cyc(1);
    bus.hit = 1'b0;
    chk("last_cycle_health", int'(bus.health), 8);
    chk("last_cycle_busy", int'(bus.busy), 1);
    wait_idle();

    // Five hits: dead, no more shots, reset restores.
    do_reset();
    for (int s = 0; s < 5; s++) begin
      shoot(4'b0001);
      cyc(3);
      bus.hit = 1'b1;
      cyc(2);
      bus.hit = 1'b0;
      wait_idle();
    end
    chk("dead_health", int'(bus.health), 0);
    chk("dead_alive", int'(bus.alive), 0);
    chk("dead_hits", int'(bus.hit_count), 5);
    bus.fire_req = 4'b1111;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (bus.who_shoot != '0 || bus.busy) n++;
    end
    bus.fire_req = '0;
    chk("dead_no_shot", n, 0);
    do_reset();
    chk("revive_health", int'(bus.health), 10);
    chk("revive_alive", int'(bus.alive), 1);

    // Reset mid-FLIGHT aborts the shot.
    shoot(4'b0100);
    cyc(5);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    chk("abort_who", int'(bus.who_shoot), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_health", int'(bus.health), 10);
    cyc(3);

`ifdef HEALTH_REGEN_EN
    do_reset();
    shoot(4'b0001);
    cyc(5);
    bus.hit = 1'b1;
    cyc(1);
    bus.hit = 1'b0;
    wait_idle();
    chk("regen_before", int'(bus.health), 8);
    cyc(8);
    chk("regen_after", int'(bus.health), 9);
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
